// File: rtl/axis_to_aes_if_pkg.sv
// Shared definitions for the AES-CTR AXIS ingress/egress glue: default widths and tkeep legality.
// Pure declarations; no latency or flow-control behaviour of its own.
package axis_to_aes_if_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int KEEP_W_DEF = DATA_W_DEF / 8;
  localparam logic [KEEP_W_DEF-1:0] ALL_ONES_KEEP = '1;

  // Widest tkeep the legality helper accepts; callers zero-extend into it.
  localparam int KEEP_MAX = 64;

  // Non-last beats must be fully populated; a last beat must be a nonzero LSB-contiguous run.
  function automatic logic keep_legal(input logic [KEEP_MAX-1:0] keep, input logic last,
                                      input int keep_w);
    logic [KEEP_MAX-1:0] mask;
    mask = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      mask[i] = (i < keep_w);
    end
    if (!last) begin
      return keep == mask;
    end
    return (keep != '0) && ((keep & ~mask) == '0) && ((keep & (keep + 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/axis_to_aes_if_if.sv
// Bundle of the AXIS slave side, the AES core input side and the error counter.
// slave is the glue's view, master the view of whatever drives the stream and the core ready.
interface axis_to_aes_if_if
  import axis_to_aes_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEEP_W = DATA_W / 8,
  parameter int IDX_W  = 32,
  parameter int ERR_W  = 16
);
  logic [DATA_W-1:0] s_tdata;
  logic [KEEP_W-1:0] s_tkeep;
  logic              s_tlast;
  logic              s_tvalid;
  logic              s_tready;

  logic [DATA_W-1:0] in_data;
  logic [KEEP_W-1:0] in_keep;
  logic              in_last;
  logic              in_first;
  logic [IDX_W-1:0]  in_blk_idx;
  logic              in_err;
  logic              in_valid;
  logic              in_ready;

  logic [ERR_W-1:0]  err_cnt;

  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid, in_ready,
    output s_tready, in_data, in_keep, in_last, in_first, in_blk_idx, in_err, in_valid, err_cnt
  );

  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tvalid, in_ready,
    input  s_tready, in_data, in_keep, in_last, in_first, in_blk_idx, in_err, in_valid, err_cnt
  );
endinterface

// File: rtl/axis_to_aes_if_skid.sv
// Two-entry skid buffer (output register + skid register), full throughput, registered up_rdy.
// 1-cycle latency; up_rdy drops on the edge that fills the skid and rises on the edge that empties it.
module axis_to_aes_if_skid #(
  parameter int         W       = 8,
  parameter logic [W-1:0] RST_DAT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_dat,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [W-1:0] dn_dat
);
  logic         out_vld;
  logic         skid_vld;
  logic         rdy_q;
  logic [W-1:0] out_dat;
  logic [W-1:0] skid_dat;
  logic         accept;
  logic         out_free;

  assign accept   = up_vld & rdy_q;
  assign out_free = ~out_vld | dn_rdy;

  // rdy_q is 0 whenever skid_vld is 1, so a skid refill never races an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
      out_dat  <= RST_DAT;
      skid_dat <= RST_DAT;
    end else if (out_free) begin
      rdy_q <= 1'b1;
      if (skid_vld) begin
        out_vld  <= 1'b1;
        out_dat  <= skid_dat;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_vld <= 1'b1;
        out_dat <= up_dat;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_vld <= 1'b1;
      skid_dat <= up_dat;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= ~skid_vld;
    end
  end

  assign up_rdy = rdy_q;
  assign dn_vld = out_vld;
  assign dn_dat = out_dat;
endmodule

// File: rtl/axis_to_aes_if.sv
// AXIS slave to AES-CTR core input: frames packets (first flag, block index, tkeep legality, error count).
// 1-cycle latency at 1 beat/cycle; s_tready is registered and drops only when the skid register is full.
module axis_to_aes_if
  import axis_to_aes_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEEP_W = DATA_W / 8,
  parameter int IDX_W  = 32,
  parameter int ERR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  axis_to_aes_if_if.slave    bus
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              first;
    logic [IDX_W-1:0]  blk_idx;
    logic              err;
  } beat_t;

  localparam beat_t RST_BEAT = '{data: '0, keep: '0, last: 1'b0, first: 1'b1,
                                 blk_idx: '0, err: 1'b0};

  logic             rdy;
  logic             accept;
  logic             illegal;
  logic             first_q;
  logic [IDX_W-1:0] idx_q;
  logic [ERR_W-1:0] err_q;
  beat_t            up_beat;
  beat_t            dn_beat;

  assign accept  = bus.s_tvalid & rdy;
  assign illegal = !keep_legal(KEEP_MAX'(bus.s_tkeep), bus.s_tlast, KEEP_W);

  // Annotations are stamped at s-side accept so they ride through the buffer with their beat.
  assign up_beat = '{data: bus.s_tdata, keep: bus.s_tkeep, last: bus.s_tlast, first: first_q,
                     blk_idx: idx_q, err: illegal};

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b1;
      idx_q   <= '0;
      err_q   <= '0;
    end else if (accept) begin
      first_q <= bus.s_tlast;
      idx_q   <= bus.s_tlast ? '0 : idx_q + 1'b1;
      if (illegal && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  axis_to_aes_if_skid #(
    .W       ($bits(beat_t)),
    .RST_DAT (RST_BEAT)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .up_vld (bus.s_tvalid),
    .up_rdy (rdy),
    .up_dat (up_beat),
    .dn_vld (bus.in_valid),
    .dn_rdy (bus.in_ready),
    .dn_dat (dn_beat)
  );

  assign bus.s_tready   = rdy;
  assign bus.in_data    = dn_beat.data;
  assign bus.in_keep    = dn_beat.keep;
  assign bus.in_last    = dn_beat.last;
  assign bus.in_first   = dn_beat.first;
  assign bus.in_blk_idx = dn_beat.blk_idx;
  assign bus.in_err     = dn_beat.err;
  assign bus.err_cnt    = err_q;
endmodule

// File: tb/tb_axis_to_aes_if.sv
// Bench for axis_to_aes_if: a default instance and a narrow one (IDX_W=2, ERR_W=4) share one stimulus.
// Reference model is a queue of in-flight beats plus packet framing state.
module tb_axis_to_aes_if;
  import axis_to_aes_if_pkg::*;

  logic         clk;
  logic         rst;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tlast;
  logic         s_tvalid;
  logic         in_ready;

  axis_to_aes_if_if                           bus_a ();
  axis_to_aes_if_if #(.IDX_W(2), .ERR_W(4))   bus_b ();

  assign bus_a.s_tdata  = s_tdata;
  assign bus_a.s_tkeep  = s_tkeep;
  assign bus_a.s_tlast  = s_tlast;
  assign bus_a.s_tvalid = s_tvalid;
  assign bus_a.in_ready = in_ready;
  assign bus_b.s_tdata  = s_tdata;
  assign bus_b.s_tkeep  = s_tkeep;
  assign bus_b.s_tlast  = s_tlast;
  assign bus_b.s_tvalid = s_tvalid;
  assign bus_b.in_ready = in_ready;

  axis_to_aes_if u_dut (.clk(clk), .rst(rst), .bus(bus_a));
  axis_to_aes_if #(.IDX_W(2), .ERR_W(4)) u_small (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         first;
    logic [31:0]  idx;
    logic         err;
  } exp_t;

  exp_t         q[$];
  bit           m_first;
  logic [31:0]  m_idx;
  int unsigned  m_errs;
  bit           ready_ok;
  bit           rst_seen;
  bit           last_acc;
  int           rdy_mode;
  int           rel;
  int           checks;
  int           errors;

  function automatic bit legal(logic [15:0] k, bit last);
    if (!last) return k == 16'hFFFF;
    for (int n = 1; n <= 16; n++) begin
      if (k == 16'((32'd1 << n) - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_ready();
    return ready_ok && (q.size() < 2);
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t h;
    chk("a_tready", bus_a.s_tready, exp_ready());
    chk("b_tready", bus_b.s_tready, exp_ready());
    chk("a_valid", bus_a.in_valid, q.size() > 0);
    chk("b_valid", bus_b.in_valid, q.size() > 0);
    chk("a_err_cnt", bus_a.err_cnt, (m_errs > 65535) ? 65535 : m_errs);
    chk("b_err_cnt", bus_b.err_cnt, (m_errs > 15) ? 15 : m_errs);
    if (q.size() > 0) begin
      h = q[0];
      chk("a_data", bus_a.in_data, h.data);
      chk("a_keep", bus_a.in_keep, h.keep);
      chk("a_last", bus_a.in_last, h.last);
      chk("a_first", bus_a.in_first, h.first);
      chk("a_idx", bus_a.in_blk_idx, h.idx);
      chk("a_err", bus_a.in_err, h.err);
      chk("b_first", bus_b.in_first, h.first);
      chk("b_idx", bus_b.in_blk_idx, h.idx % 4);
      chk("b_err", bus_b.in_err, h.err);
    end
  endtask

  // One clock: drive in_ready, check at negedge, then advance the model at posedge.
  task automatic step();
    bit acc;
    bit drn;
    exp_t e;
    case (rdy_mode)
      0:       in_ready = 1'b1;
      1:       in_ready = ($urandom_range(0, 3) != 0);
      2:       in_ready = !(rel >= 2 && rel <= 5);
      default: in_ready = 1'b0;
    endcase
    rel++;
    @(negedge clk);
    if (rst_seen) check_all();
    acc = s_tvalid && exp_ready();
    drn = (q.size() > 0) && in_ready;
    last_acc = acc && !rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_first  = 1'b1;
      m_idx    = '0;
      m_errs   = 0;
      ready_ok = 1'b0;
      rst_seen = 1'b1;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.data  = s_tdata;
        e.keep  = s_tkeep;
        e.last  = s_tlast;
        e.first = m_first;
        e.idx   = m_idx;
        e.err   = !legal(s_tkeep, s_tlast);
        q.push_back(e);
        if (e.err) m_errs++;
        m_first = s_tlast;
        m_idx   = s_tlast ? 32'd0 : m_idx + 32'd1;
      end
      ready_ok = 1'b1;
    end
    #1;
  endtask

  task automatic send(logic [127:0] d, logic [15:0] k, logic l);
    int tries;
    tries    = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    do begin
      step();
      tries++;
    end while (!last_acc && tries < 100);
    checks++;
    assert (last_acc) else begin
      errors++;
      $error("FAIL accept_timeout observed=%0d expected=1", last_acc);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic idle(int n);
    s_tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic flush();
    int tries;
    tries    = 0;
    s_tvalid = 1'b0;
    rdy_mode = 0;
    while (q.size() > 0 && tries < 20) begin
      step();
      tries++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", q.size());
    end
    step();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [15:0] k;
    logic        l;
    int          n;
    checks   = 0;
    errors   = 0;
    rst_seen = 1'b0;
    ready_ok = 1'b0;
    m_first  = 1'b1;
    m_idx    = '0;
    m_errs   = 0;
    rdy_mode = 0;
    rel      = 0;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    in_ready = 1'b0;
    #1;
    step();
    step();

    // Reset values
    chk("rst_tready", bus_a.s_tready, 1'b0);
    chk("rst_valid", bus_a.in_valid, 1'b0);
    chk("rst_first", bus_a.in_first, 1'b1);
    chk("rst_idx", bus_a.in_blk_idx, 32'd0);
    chk("rst_err", bus_a.in_err, 1'b0);
    chk("rst_last", bus_a.in_last, 1'b0);
    chk("rst_err_cnt", bus_a.err_cnt, 16'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", bus_a.s_tready, 1'b1);

    // Throughput: 4-beat packet, in_ready held high
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) send(rnd128(), ALL_ONES_KEEP, i == 3);
    flush();

    // Backpressure: 8 back-to-back beats, in_ready low for cycles 2-5
    rdy_mode = 2;
    rel      = 0;
    for (int i = 0; i < 8; i++) send(rnd128(), 16'hFFFF, i == 7);
    flush();

    // Partial last beats: legal then illegal
    send(rnd128(), 16'hFFFF, 1'b0);
    send(rnd128(), 16'h00FF, 1'b1);
    send(rnd128(), 16'hFFFF, 1'b0);
    send(rnd128(), 16'h0F0F, 1'b1);
    flush();
    chk("err_cnt_one", bus_a.err_cnt, 16'd1);

    // Illegal non-last beats until the narrow counter saturates
    for (int i = 0; i < 20; i++) send(rnd128(), 16'h7FFF, 1'b0);
    send(rnd128(), 16'h0001, 1'b1);
    flush();
    chk("err_sat_b", bus_b.err_cnt, 4'hF);
    chk("err_cnt_a21", bus_a.err_cnt, 16'd21);

    // Reset mid-packet with the skid register full
    rdy_mode = 3;
    send(rnd128(), 16'hFFFF, 1'b0);
    send(rnd128(), 16'hFFFF, 1'b0);
    idle(1);
    chk("pre_rst_tready", bus_a.s_tready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("in_rst_valid", bus_a.in_valid, 1'b0);
    chk("in_rst_tready", bus_a.s_tready, 1'b0);
    rdy_mode = 0;
    send(rnd128(), 16'hFFFF, 1'b0);
    send(rnd128(), 16'h0003, 1'b1);
    flush();

    // Index wrap on the IDX_W=2 instance
    for (int i = 0; i < 6; i++) send(rnd128(), 16'hFFFF, i == 5);
    flush();

    // Randomised traffic with random core backpressure
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      l = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        k = 16'($urandom);
      end else if (l) begin
        n = $urandom_range(1, 16);
        k = 16'((32'd1 << n) - 1);
      end else begin
        k = 16'hFFFF;
      end
      send(rnd128(), k, l);
      if ($urandom_range(0, 2) == 0) idle(1);
      rdy_mode = 1;
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_to_aes_if.md
Name: axis_to_aes_if

Overview:
AXI4-Stream slave that feeds the AES-CTR core input handshake. It is the ingress counterpart of the core's AXIS egress glue. It contains a full-throughput two-entry skid buffer with a registered s_tready. It also frames packets: first-beat marker, per-packet block index for CTR counter derivation, and tkeep legality checking with a saturating error counter.

Parameters:
DATA_W, 128, stream data width in bits; must be a multiple of 8.
KEEP_W, DATA_W/8, tkeep width; bit i qualifies byte tdata[8i+7:8i].
IDX_W, 32, width of the per-packet block index.
ERR_W, 16, width of the saturating error counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
s_tdata  in  DATA_W  AXIS slave data.
s_tkeep  in  KEEP_W  AXIS slave byte qualifiers.
s_tlast  in  1  AXIS slave end of packet.
s_tvalid  in  1  AXIS slave valid.
s_tready  out  1  AXIS slave ready; registered.
in_data  out  DATA_W  data to AES core.
in_keep  out  KEEP_W  byte qualifiers to AES core.
in_last  out  1  last block of packet.
in_first  out  1  first block of packet.
in_blk_idx  out  IDX_W  block index within packet, starting at 0.
in_err  out  1  this beat violated the tkeep rules.
in_valid  out  1  beat valid to AES core.
in_ready  in  1  AES core accepts beat.
err_cnt  out  ERR_W  count of illegal beats; saturates at all-ones.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; there is no asynchronous reset.
- Reset values: s_tready=0, in_valid=0, in_first=1, in_blk_idx=0, in_err=0, in_last=0, err_cnt=0. Data and keep outputs are don't-care.
- s_tready rises to 1 on the first clock edge after rst deasserts, provided the skid register is empty.
- Handshake: a transfer occurs when valid and ready are both high. AXIS rules apply on both sides. Once in_valid rises, it and all in_* payload hold stable until in_ready. in_valid never depends combinationally on in_ready.
- Latency: a beat accepted at edge N appears on in_* after edge N. This gives 1 cycle of latency and 1 beat/cycle sustained throughput with in_ready held high.
- Skid buffer: output register plus one skid register.
  - Output register empty: an accepted beat loads the output register.
  - Output register full and in_ready=0 at accept: the beat loads the skid register, and s_tready drops at the next edge.
  - When the output register drains: the skid contents move into the output register and s_tready rises at the next edge.
  - Beats are never dropped, duplicated, or reordered.
- Framing happens at s-side accept, so annotations travel with the beat.
  - first flag: set at reset, cleared after accepting a beat with tlast=0, set again after accepting a beat with tlast=1.
  - blk_idx: increments by 1 per accepted beat, returns to 0 after a tlast beat, and wraps modulo 2^IDX_W with no flag.
- tkeep legality:
  - A non-last beat requires tkeep all-ones.
  - A last beat requires tkeep nonzero and LSB-contiguous, i.e. 2^n-1 for n in 1..KEEP_W.
  - An illegal beat is still forwarded unchanged, with in_err=1.
  - err_cnt increments by 1 at the s-side accept of an illegal beat and saturates.
- Simultaneous events: accept on s-side and drain on the core side in the same cycle gives pass-through with no skid use. Skid full, output draining, and a new s_tvalid in the same cycle: s_tready is 0, so nothing is accepted that cycle.
- Reset mid-packet discards both registers. The next accepted beat has in_first=1 and in_blk_idx=0. err_cnt clears.
- No tuser or tid support. tstrb is not present and is treated as equal to tkeep.

Decomposition:
- Shared header aes_axis_defs.vh holds:
  - default DATA_W and KEEP_W, shared with the egress glue;
  - the keep_legal(keep, last) function;
  - the localparam ALL_ONES_KEEP.
- Natural sub-module: axis_skid_buf, a generic two-entry skid buffer parameterised by payload width. Payload is {data, keep, last, first, blk_idx, err}.
- Framing, legality checking, and err_cnt live in the top level, about 200 lines in total.

Test Plan:
- Throughput: reset, then in_ready=1 and a 4-beat packet with tkeep=16'hFFFF on each beat and tlast on beat 3. Expect in_valid one cycle after each accept, blk_idx 0,1,2,3, in_first only on beat 0, in_last only on beat 3, s_tready stuck at 1, err_cnt=0.
- Backpressure: stream 8 back-to-back beats and hold in_ready=0 for cycles 2-5. Expect exactly 2 beats buffered, s_tready=0 from the following edge, all 8 beats delivered in order with payload intact, no loss or duplication.
- Partial last: a 2-beat packet with last-beat tkeep=16'h00FF. Expect in_err=0 on both beats. Then a last-beat tkeep=16'h0F0F: expect in_err=1 and err_cnt=1, with data forwarded unchanged.
- Illegal non-last: tkeep=16'h7FFF with tlast=0. Expect in_err=1 and err_cnt to increment. Preload err_cnt to 16'hFFFF using repeated errors: expect it to stay at 16'hFFFF.
- Reset mid-packet: accept 2 beats of a packet, assert rst for 1 cycle while the skid is full, then send a new beat. Expect in_valid=0 and s_tready=0 during rst, and the new beat to carry in_first=1 and in_blk_idx=0.
- Index wrap with IDX_W=2: a 6-beat packet. Expect blk_idx 0,1,2,3,0,1, with in_first set only on beat 0.
